// File: rtl/gfx256_fragment_tex_if.sv
// Texture read port between the fragment stage (master) and the wishbone reader (slave).
// One request fetches one MDW-bit line from a line-aligned byte address.
interface gfx256_fragment_tex_if #(
  parameter int MDW = 256
);
  logic           texture_request_o;
  logic [31:0]    texture_addr_o;
  logic           texture_ack_i;
  logic [MDW-1:0] texture_data_i;
  logic           wbm_busy_i;

  modport master (
    output texture_request_o, texture_addr_o,
    input  texture_ack_i, texture_data_i, wbm_busy_i
  );

  modport slave (
    input  texture_request_o, texture_addr_o,
    output texture_ack_i, texture_data_i, wbm_busy_i
  );
endinterface

// File: rtl/gfx256_fragment_tex.sv
// Fragment texturing stage: optional texel fetch through a one-line cache,
// colorkey discard, then hand-off of pixel and color to the blender.
module gfx256_fragment_tex #(
  parameter int point_width = 16,
  parameter int MDW         = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [point_width-1:0] pixel_x_i,
  input  logic [point_width-1:0] pixel_y_i,
  input  logic [point_width-1:0] pixel_z_i,
  input  logic [point_width-1:0] u_i,
  input  logic [point_width-1:0] v_i,
  input  logic [7:0]             a_i,
  input  logic [31:0]            color_i,
  input  logic                   write_i,
  output logic                   ack_o,
  input  logic                   texture_enable_i,
  input  logic [31:0]            tex0_base_i,
  input  logic [point_width-1:0] tex0_size_x_i,
  input  logic [point_width-1:0] tex0_size_y_i,
  input  logic [1:0]             color_depth_i,
  input  logic                   colorkey_enable_i,
  input  logic [31:0]            colorkey_i,
  gfx256_fragment_tex_if.master  tex_bus,
  output logic [point_width-1:0] pixel_x_o,
  output logic [point_width-1:0] pixel_y_o,
  output logic [point_width-1:0] pixel_z_o,
  output logic [7:0]             a_o,
  output logic [31:0]            color_o,
  output logic                   write_o,
  input  logic                   ack_i
);
  localparam int OFFW = $clog2(MDW / 8);
  localparam int TAGW = 32 - OFFW;

  typedef enum logic [2:0] {IDLE, ADDR, FETCH, KEY, WRITE} state_t;

  state_t                 state_q, state_d;
  logic [point_width-1:0] x_q, x_d, y_q, y_d, z_q, z_d, u_q, u_d, v_q, v_d;
  logic [7:0]             a_q, a_d;
  logic [31:0]            color_q, color_d;
  logic                   write_q, write_d, ack_q, ack_d, req_q, req_d;
  logic [31:0]            addr_q, addr_d;
  logic [OFFW-2:0]        off_q, off_d;
  logic                   d16_q, d16_d;
  logic [MDW-1:0]         line_q, line_d;
  logic [TAGW-1:0]        tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic [31:0]            base_prev_q, base_prev_d;
  logic [1:0]             depth_prev_q, depth_prev_d;

  logic [point_width-1:0] u_clamp, v_clamp;
  logic [31:0]            tex_idx, byte_addr, lane32, texel;
  logic [15:0]            lane16;
  logic                   is16, key_match, inval;

  always_comb begin
    is16 = (color_depth_i == 2'b01);
    if (tex0_size_x_i == '0)         u_clamp = '0;
    else if (u_q >= tex0_size_x_i)   u_clamp = tex0_size_x_i - point_width'(1);
    else                             u_clamp = u_q;
    if (tex0_size_y_i == '0)         v_clamp = '0;
    else if (v_q >= tex0_size_y_i)   v_clamp = tex0_size_y_i - point_width'(1);
    else                             v_clamp = v_q;
    tex_idx   = 32'(v_clamp) * 32'(tex0_size_x_i) + 32'(u_clamp);
    byte_addr = tex0_base_i + tex_idx * (is16 ? 32'd2 : 32'd4);

    // off_q holds byte address bits [OFFW-1:1]; lanes are little-endian within the line
    lane32    = line_q[{off_q[OFFW-2:1], 5'b0} +: 32];
    lane16    = line_q[{off_q, 4'b0} +: 16];
    texel     = d16_q ? {16'h0, lane16} : lane32;
    key_match = d16_q ? (texel[15:0] == colorkey_i[15:0]) : (texel == colorkey_i);
    inval     = (tex0_base_i != base_prev_q) || (color_depth_i != depth_prev_q);
  end

  always_comb begin
    state_d      = state_q;
    x_d = x_q; y_d = y_q; z_d = z_q; u_d = u_q; v_d = v_q; a_d = a_q;
    color_d      = color_q;
    write_d      = write_q;
    ack_d        = 1'b0;
    req_d        = req_q;
    addr_d       = addr_q;
    off_d        = off_q;
    d16_d        = d16_q;
    line_d       = line_q;
    tag_d        = tag_q;
    valid_d      = valid_q;
    base_prev_d  = tex0_base_i;
    depth_prev_d = color_depth_i;

    case (state_q)
      IDLE: begin
        // ~ack_q stops the just-acked pixel (write_i still high) from re-entering
        if (write_i && !ack_q) begin
          x_d = pixel_x_i; y_d = pixel_y_i; z_d = pixel_z_i;
          u_d = u_i; v_d = v_i; a_d = a_i;
          color_d = color_i;
          if (texture_enable_i) begin
            state_d = ADDR;
          end else begin
            write_d = 1'b1;
            state_d = WRITE;
          end
        end
      end
      ADDR: begin
        addr_d = {byte_addr[31:OFFW], {OFFW{1'b0}}};
        off_d  = byte_addr[OFFW-1:1];
        d16_d  = is16;
        if (valid_q && (tag_q == byte_addr[31:OFFW])) begin
          state_d = KEY;
        end else begin
          req_d   = ~tex_bus.wbm_busy_i;
          state_d = FETCH;
        end
      end
      FETCH: begin
        req_d = req_q | ~tex_bus.wbm_busy_i;
        if (tex_bus.texture_ack_i) begin
          req_d   = 1'b0;
          line_d  = tex_bus.texture_data_i;
          tag_d   = addr_q[31:OFFW];
          valid_d = 1'b1;
          state_d = KEY;
        end
      end
      KEY: begin
        if (colorkey_enable_i && key_match) begin
          ack_d   = 1'b1;
          state_d = IDLE;
        end else begin
          color_d = texel;
          write_d = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ack_i) begin
          write_d = 1'b0;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A texture setup change wins over a same-cycle fill; the fill data is still used
    if (inval) valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      x_q <= '0; y_q <= '0; z_q <= '0; u_q <= '0; v_q <= '0; a_q <= '0;
      color_q <= '0; write_q <= 1'b0; ack_q <= 1'b0; req_q <= 1'b0;
      addr_q <= '0; off_q <= '0; d16_q <= 1'b0;
      line_q <= '0; tag_q <= '0; valid_q <= 1'b0;
      base_prev_q <= '0; depth_prev_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d; y_q <= y_d; z_q <= z_d; u_q <= u_d; v_q <= v_d; a_q <= a_d;
      color_q <= color_d; write_q <= write_d; ack_q <= ack_d; req_q <= req_d;
      addr_q <= addr_d; off_q <= off_d; d16_q <= d16_d;
      line_q <= line_d; tag_q <= tag_d; valid_q <= valid_d;
      base_prev_q <= base_prev_d; depth_prev_q <= depth_prev_d;
    end
  end

  assign pixel_x_o = x_q;
  assign pixel_y_o = y_q;
  assign pixel_z_o = z_q;
  assign a_o       = a_q;
  assign color_o   = color_q;
  assign write_o   = write_q;
  assign ack_o     = ack_q;
  assign tex_bus.texture_request_o = req_q;
  assign tex_bus.texture_addr_o    = addr_q;
endmodule

// File: tb/tb_gfx256_fragment_tex.sv
// Bench for gfx256_fragment_tex: directed pixels checked against an address/texel/cache
// model, a per-cycle output monitor, and hand-computed literal expectations.
module tb_gfx256_fragment_tex;
  localparam int PW  = 16;
  localparam int MDW = 256;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [PW-1:0] pixel_x_i = '0, pixel_y_i = '0, pixel_z_i = '0, u_i = '0, v_i = '0;
  logic [7:0]    a_i = '0;
  logic [31:0]   color_i = '0;
  logic          write_i = 1'b0, texture_enable_i = 1'b0;
  logic [31:0]   tex0_base_i = '0;
  logic [PW-1:0] tex0_size_x_i = '0, tex0_size_y_i = '0;
  logic [1:0]    color_depth_i = 2'b00;
  logic          colorkey_enable_i = 1'b0;
  logic [31:0]   colorkey_i = '0;
  logic [PW-1:0] pixel_x_o, pixel_y_o, pixel_z_o;
  logic [7:0]    a_o;
  logic [31:0]   color_o;
  logic          write_o, ack_o;
  logic          ack_i = 1'b0;

  gfx256_fragment_tex_if #(.MDW(MDW)) tex_bus ();

  gfx256_fragment_tex #(.point_width(PW), .MDW(MDW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
    .u_i(u_i), .v_i(v_i), .a_i(a_i), .color_i(color_i),
    .write_i(write_i), .ack_o(ack_o), .texture_enable_i(texture_enable_i),
    .tex0_base_i(tex0_base_i), .tex0_size_x_i(tex0_size_x_i), .tex0_size_y_i(tex0_size_y_i),
    .color_depth_i(color_depth_i), .colorkey_enable_i(colorkey_enable_i), .colorkey_i(colorkey_i),
    .tex_bus(tex_bus),
    .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
    .a_o(a_o), .color_o(color_o), .write_o(write_o), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Texture memory contents: word i of the line at address L is (L+i) ^ 5A000000.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int i);
    return (line + 32'(i)) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [MDW-1:0] mem_line(input logic [31:0] line);
    logic [MDW-1:0] r;
    for (int i = 0; i < MDW / 32; i++) r[i*32 +: 32] = mem_word(line, i);
    return r;
  endfunction

  function automatic logic [31:0] model_byte(input int unsigned u, input int unsigned v,
      input logic [31:0] base, input int unsigned sx, input int unsigned sy, input bit d16);
    int unsigned uc, vc;
    logic [31:0] idx;
    uc  = (sx == 0) ? 0 : ((u < sx) ? u : sx - 1);
    vc  = (sy == 0) ? 0 : ((v < sy) ? v : sy - 1);
    idx = vc * sx + uc;
    return base + idx * (d16 ? 32'd2 : 32'd4);
  endfunction

  function automatic logic [31:0] model_texel(input logic [31:0] b, input bit d16);
    logic [31:0] w;
    w = mem_word({b[31:5], 5'b0}, int'(b[4:2]));
    if (!d16) return w;
    return b[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
  endfunction

  // Model of the one-line cache, plus the expectation the monitor compares against.
  bit          m_valid = 1'b0;
  logic [26:0] m_tag = '0;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_byte, exp_color;
  logic [PW-1:0] exp_x, exp_y, exp_z;
  logic [7:0]  exp_a;

  logic prev_req = 1'b0, prev_busy = 1'b0, prev_ack = 1'b0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (exp_valid && write_o) begin
        check("wr_color", color_o, exp_color);
        check("wr_xy", {pixel_x_o, pixel_y_o}, {exp_x, exp_y});
        check("wr_za", {pixel_z_o, 8'h00, a_o}, {exp_z, 8'h00, exp_a});
      end
      if (exp_valid && tex_bus.texture_request_o)
        check("req_addr", tex_bus.texture_addr_o, {exp_byte[31:5], 5'b0});
      if (tex_bus.texture_request_o && !prev_req)
        check("req_rise_busy", {31'b0, prev_busy}, 32'd0);
      if (ack_o && prev_ack)
        check("ack_one_cycle", {31'b0, ack_o & prev_ack}, 32'd0);
    end
    prev_req  <= tex_bus.texture_request_o;
    prev_busy <= tex_bus.wbm_busy_i;
    prev_ack  <= ack_o;
  end

  task automatic set_tex(input logic [31:0] base, input logic [1:0] depth);
    if (base != tex0_base_i || depth != color_depth_i) m_valid = 1'b0;
    tex0_base_i   = base;
    color_depth_i = depth;
    @(posedge clk_i); #1;
  endtask

  task automatic run_pixel(input string name, input logic [PW-1:0] u, input logic [PW-1:0] v,
      input logic [31:0] col, input bit tex, input int busy_cycles, output logic [31:0] got_color);
    bit d16, miss, discard, done;
    logic [31:0] texel;
    int first_req, first_wr, ack_cyc, done_cyc, req_cnt, exp_lat, lat;
    d16      = (color_depth_i == 2'b01);
    exp_byte = model_byte(u, v, tex0_base_i, tex0_size_x_i, tex0_size_y_i, d16);
    texel    = model_texel(exp_byte, d16);
    miss     = tex && !(m_valid && m_tag == exp_byte[31:5]);
    discard  = tex && colorkey_enable_i &&
               (d16 ? (texel[15:0] == colorkey_i[15:0]) : (texel == colorkey_i));
    exp_color = tex ? texel : col;
    exp_x = PW'($urandom); exp_y = PW'($urandom); exp_z = PW'($urandom); exp_a = 8'($urandom);
    pixel_x_i = exp_x; pixel_y_i = exp_y; pixel_z_i = exp_z; a_i = exp_a;
    u_i = u; v_i = v; color_i = col; texture_enable_i = tex;
    tex_bus.wbm_busy_i = (busy_cycles > 0);
    exp_valid = 1'b1;
    write_i = 1'b1;
    first_req = 0; first_wr = 0; ack_cyc = 0; done_cyc = 0; req_cnt = 0; done = 0;
    got_color = '0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(posedge clk_i); #1;
      if (tex_bus.texture_ack_i) begin
        ack_cyc = c;
        tex_bus.texture_ack_i = 1'b0;
      end
      if (c >= busy_cycles) tex_bus.wbm_busy_i = 1'b0;
      if (tex_bus.texture_request_o && ack_cyc == 0) begin
        req_cnt++;
        if (first_req == 0) first_req = c;
        if (req_cnt == 2) begin
          tex_bus.texture_ack_i  = 1'b1;
          tex_bus.texture_data_i = mem_line(tex_bus.texture_addr_o);
        end
      end
      if (write_o && first_wr == 0) begin
        first_wr  = c;
        got_color = color_o;
      end
      if (write_o) ack_i = 1'b1;
      if (ack_o) begin
        done = 1'b1;
        done_cyc = c;
      end
    end
    write_i = 1'b0; ack_i = 1'b0; tex_bus.texture_ack_i = 1'b0; tex_bus.wbm_busy_i = 1'b0;
    exp_valid = 1'b0;
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_miss"}, {31'b0, first_req != 0}, {31'b0, miss});
    check({name, "_written"}, {31'b0, first_wr != 0}, {31'b0, !discard});
    // texture off: WRITE right after accept; hit: ADDR, KEY, then write; miss: KEY after the fill
    exp_lat = !tex ? 1 : (miss ? ack_cyc + 1 : 3);
    lat     = discard ? done_cyc : first_wr;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (busy_cycles > 0) check({name, "_req_after_busy"}, {31'b0, first_req > busy_cycles}, 32'd1);
    if (miss) begin
      m_valid = 1'b1;
      m_tag   = exp_byte[31:5];
    end
    $display("pixel %s: u=%0d v=%0d color=%h miss=%0d discard=%0d latency=%0d",
             name, u, v, got_color, miss, discard, lat);
    @(posedge clk_i); #1;
  endtask

  logic [31:0] got;
  bit          seen;

  initial begin
    tex_bus.texture_ack_i  = 1'b0;
    tex_bus.texture_data_i = '0;
    tex_bus.wbm_busy_i     = 1'b0;

    // Model pins against hand-computed addresses and texels
    check("pin_addr_u3v2",  model_byte(3, 2, 32'h1000, 64, 64, 0), 32'h0000_120C);
    check("pin_addr_clamp", model_byte(100, 2, 32'h1000, 64, 64, 0), 32'h0000_12FC);
    check("pin_addr_16bpp", model_byte(5, 1, 32'h2000, 16, 16, 1), 32'h0000_202A);
    check("pin_addr_size0", model_byte(7, 9, 32'h4000, 0, 0, 0), 32'h0000_4000);
    check("pin_addr_wrap",  model_byte(8, 0, 32'hFFFF_FFF0, 64, 64, 0), 32'h0000_0010);
    check("pin_texel_16",   model_texel(32'h0000_202A, 1), 32'h0000_5A00);

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_request", {31'b0, tex_bus.texture_request_o}, 32'd0);
    check("rst_write",   {31'b0, write_o}, 32'd0);
    check("rst_ack",     {31'b0, ack_o}, 32'd0);
    check("rst_color",   color_o, 32'd0);
    check("rst_addr",    tex_bus.texture_addr_o, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run_pixel("notex", 16'd0, 16'd0, 32'h1122_3344, 0, 0, got);
    check("notex_color_lit", got, 32'h1122_3344);

    tex0_size_x_i = 16'd64; tex0_size_y_i = 16'd64;
    set_tex(32'h0000_1000, 2'b00);
    run_pixel("miss_u3v2", 16'd3, 16'd2, 32'hDEAD_BEEF, 1, 0, got);
    check("miss_color_lit", got, 32'h5A00_1203);
    run_pixel("hit_u4v2", 16'd4, 16'd2, 32'h0, 1, 0, got);
    check("hit_color_lit", got, 32'h5A00_1204);

    colorkey_enable_i = 1'b1; colorkey_i = 32'h5A00_1203;
    run_pixel("key_discard", 16'd3, 16'd2, 32'h0, 1, 0, got);
    run_pixel("key_pass", 16'd4, 16'd2, 32'h0, 1, 0, got);
    colorkey_enable_i = 1'b0;

    run_pixel("clamp_busy", 16'd100, 16'd2, 32'h0, 1, 5, got);
    check("clamp_color_lit", got, 32'h5A00_12E7);

    set_tex(32'h0000_3000, 2'b00);
    set_tex(32'h0000_1000, 2'b00);
    run_pixel("inval_refetch", 16'd4, 16'd2, 32'h0, 1, 0, got);

    tex0_size_x_i = 16'd16; tex0_size_y_i = 16'd16;
    set_tex(32'h0000_2000, 2'b01);
    run_pixel("bpp16", 16'd5, 16'd1, 32'h0, 1, 0, got);
    check("bpp16_color_lit", got, 32'h0000_5A00);
    colorkey_enable_i = 1'b1; colorkey_i = 32'hFFFF_5A00;
    run_pixel("bpp16_key", 16'd5, 16'd1, 32'h0, 1, 0, got);
    colorkey_enable_i = 1'b0;

    tex0_size_x_i = 16'd0; tex0_size_y_i = 16'd0;
    set_tex(32'h0000_4000, 2'b00);
    run_pixel("size0", 16'd7, 16'd9, 32'h0, 1, 0, got);
    check("size0_color_lit", got, 32'h5A00_4000);

    tex0_size_x_i = 16'd64; tex0_size_y_i = 16'd64;
    set_tex(32'hFFFF_FFF0, 2'b00);
    run_pixel("wrap", 16'd8, 16'd0, 32'h0, 1, 0, got);
    check("wrap_color_lit", got, 32'h5A00_0004);

    // Reset while a fetch is outstanding; no texture ack is ever given here
    set_tex(32'h0000_1000, 2'b00);
    u_i = 16'd0; v_i = 16'd10; texture_enable_i = 1'b1; write_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk_i); #1;
      seen = tex_bus.texture_request_o;
    end
    check("midfetch_req_seen", {31'b0, seen}, 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    check("midfetch_rst_request", {31'b0, tex_bus.texture_request_o}, 32'd0);
    check("midfetch_rst_write",   {31'b0, write_o}, 32'd0);
    check("midfetch_rst_ack",     {31'b0, ack_o}, 32'd0);
    write_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni  = 1'b1;
    m_valid = 1'b0;
    @(posedge clk_i); #1;
    run_pixel("post_rst_miss", 16'd0, 16'd10, 32'h0, 1, 0, got);
    check("post_rst_color_lit", got, 32'h5A00_1A00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
